iter_div_unit: RTL and testbench

- Iterative radix-2 integer divide/remainder responder for the RV64M DIV/REM family.
- Sits behind the execute stage. The execute stage holds div_ready high, together with stable operands and opcode, until it sees a one-cycle div_finish, and stalls the scoreboard while ready && ~finish.
- The block computes the quotient or remainder over multiple cycles and returns one 64-bit result per request.

---
 rtl/iter_div_unit.sv | 193 +++++++++++++++++++
 tb/tb_iter_div_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for the RV64M DIV/REM family.
// Returns one XLEN-bit quotient or remainder per request held on div_ready.
module iter_div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_ready,
  input  logic [7:0]      inst_opcode,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] diviser,
  output logic [XLEN-1:0] div_rem_data,
  output logic            div_finish
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  // Opcode encodings shared with the execute-stage decoder.
  localparam logic [7:0] INST_DIV   = 8'h50;
  localparam logic [7:0] INST_DIVU  = 8'h51;
  localparam logic [7:0] INST_REM   = 8'h52;
  localparam logic [7:0] INST_REMU  = 8'h53;
  localparam logic [7:0] INST_DIVW  = 8'h54;
  localparam logic [7:0] INST_DIVUW = 8'h55;
  localparam logic [7:0] INST_REMW  = 8'h56;
  localparam logic [7:0] INST_REMUW = 8'h57;

  // Most-negative dividends; the W form is the sign-extended 32-bit minimum.
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              sel_rem_q, sel_rem_d;
  logic              w_op_q, w_op_d;
  logic              finish_q, finish_d;

  logic              op_valid, op_signed, op_rem, op_w;
  logic              dvd_neg, dvs_neg, div_zero, overflow;
  logic [XLEN-1:0]   dvd_abs, dvs_abs;
  logic [XLEN:0]     rem_sh, trial;
  logic              step_ok;
  logic [XLEN-1:0]   rem_step, quo_step;

  // Select quotient or remainder and apply W-form sign extension of bit 31.
  function automatic logic [XLEN-1:0] pick_result(input logic [XLEN-1:0] quo,
                                                  input logic [XLEN-1:0] rem,
                                                  input logic            sel_rem,
                                                  input logic            w_op);
    logic [XLEN-1:0] res;
    res = sel_rem ? rem : quo;
    if (w_op) res = {{(XLEN-32){res[31]}}, res[31:0]};
    return res;
  endfunction

  // Opcode decode into signedness, result select and W form.
  always_comb begin
    op_valid  = 1'b1;
    op_signed = 1'b0;
    op_rem    = 1'b0;
    op_w      = 1'b0;
    case (inst_opcode)
      INST_DIV:   op_signed = 1'b1;
      INST_DIVU:  op_signed = 1'b0;
      INST_REM:   begin op_signed = 1'b1; op_rem = 1'b1; end
      INST_REMU:  op_rem = 1'b1;
      INST_DIVW:  begin op_signed = 1'b1; op_w = 1'b1; end
      INST_DIVUW: op_w = 1'b1;
      INST_REMW:  begin op_signed = 1'b1; op_rem = 1'b1; op_w = 1'b1; end
      INST_REMUW: begin op_rem = 1'b1; op_w = 1'b1; end
      default:    op_valid = 1'b0;
    endcase
  end

  // Operand magnitudes and fast-path detection; W operands arrive pre-extended,
  // so the W overflow case is recognised on its sign-extended minimum.
  assign dvd_neg  = op_signed & dividend[XLEN-1];
  assign dvs_neg  = op_signed & diviser[XLEN-1];
  assign dvd_abs  = dvd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -diviser : diviser;
  assign div_zero = (diviser == '0);
  assign overflow = op_signed && (dividend == (op_w ? MIN_W : MIN_D)) && (&diviser);

  // One restoring step on the shifted {rem,quo} pair.
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign step_ok  = ~trial[XLEN];
  assign rem_step = step_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], step_ok};

  // Next-state and output logic; results are loaded on entry to DONE.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    w_op_d    = w_op_q;
    data_d    = data_q;
    finish_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_ready && op_valid) begin
          sel_rem_d = op_rem;
          w_op_d    = op_w;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          dvs_d     = dvs_abs;
          if (div_zero) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
            data_d   = pick_result('1, dividend, op_rem, op_w);
          end else if (overflow) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
            data_d   = pick_result(dividend, '0, op_rem, op_w);
          end else begin
            rem_d   = '0;
            quo_d   = dvd_abs;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!div_ready) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
            data_d   = pick_result(neg_quo_q ? -quo_step : quo_step,
                                   neg_rem_q ? -rem_step : rem_step,
                                   sel_rem_q, w_op_q);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      w_op_q    <= 1'b0;
      data_q    <= '0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      w_op_q    <= w_op_d;
      data_q    <= data_d;
      finish_q  <= finish_d;
    end
  end

  assign div_rem_data = data_q;
  assign div_finish   = finish_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed vectors, abort/reset,
// back-to-back and randomized operations against an arithmetic model.
module tb_iter_div_unit;

  localparam int unsigned XLEN = 64;
  localparam logic [7:0] OP_DIV   = 8'h50;
  localparam logic [7:0] OP_DIVU  = 8'h51;
  localparam logic [7:0] OP_REM   = 8'h52;
  localparam logic [7:0] OP_REMU  = 8'h53;
  localparam logic [7:0] OP_DIVW  = 8'h54;
  localparam logic [7:0] OP_DIVUW = 8'h55;
  localparam logic [7:0] OP_REMW  = 8'h56;
  localparam logic [7:0] OP_REMUW = 8'h57;
  localparam int ITER_LAT = 65;
  localparam int FAST_LAT = 1;
  localparam int BUDGET   = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            div_ready;
  logic [7:0]      inst_opcode;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] diviser;
  logic [XLEN-1:0] div_rem_data;
  logic            div_finish;

  int checks = 0;
  int errors = 0;

  iter_div_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_ready    (div_ready),
    .inst_opcode  (inst_opcode),
    .dividend     (dividend),
    .diviser      (diviser),
    .div_rem_data (div_rem_data),
    .div_finish   (div_finish)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // RISC-V M-extension semantics computed directly with language arithmetic.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    r = '0; r32 = '0;
    case (op)
      OP_DIV: begin
        if (b == 64'd0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = sa / sb;
      end
      OP_REM: begin
        if (b == 64'd0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
        else r = sa % sb;
      end
      OP_DIVU: begin
        if (b == 64'd0) r = '1;
        else r = a / b;
      end
      OP_REMU: begin
        if (b == 64'd0) r = a;
        else r = a % b;
      end
      OP_DIVW: begin
        if (ub32 == 32'd0) r32 = '1;
        else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
        else r32 = sa32 / sb32;
      end
      OP_REMW: begin
        if (ub32 == 32'd0) r32 = ua32;
        else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = '0;
        else r32 = sa32 % sb32;
      end
      OP_DIVUW: begin
        if (ub32 == 32'd0) r32 = '1;
        else r32 = ua32 / ub32;
      end
      OP_REMUW: begin
        if (ub32 == 32'd0) r32 = ua32;
        else r32 = ua32 % ub32;
      end
      default: r = '0;
    endcase
    if (op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW}) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // Drive one request and wait for its finish pulse; lat = -1 on timeout.
  task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] data);
    @(negedge clk);
    div_ready = 1'b1; inst_opcode = op; dividend = a; diviser = b;
    lat = -1; data = '0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (div_finish) begin
        lat = n; data = div_rem_data;
        break;
      end
    end
    div_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (div_rem_data !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h expected %h", div_rem_data, 64'd0);
    end
    checks++;
    if (div_finish !== 1'b0) begin
      errors++; $display("FAIL reset_finish: got %b expected 0", div_finish);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0]  t_op  [8];
    logic [63:0] t_a   [8];
    logic [63:0] t_b   [8];
    logic [63:0] t_exp [8];
    int          t_lat [8];
    int          lat;
    logic [63:0] got;
    t_op[0] = OP_DIV;   t_a[0] = -64'sd7; t_b[0] = 64'd2; t_exp[0] = 64'hFFFF_FFFF_FFFF_FFFD; t_lat[0] = ITER_LAT;
    t_op[1] = OP_REM;   t_a[1] = -64'sd7; t_b[1] = 64'd2; t_exp[1] = 64'hFFFF_FFFF_FFFF_FFFF; t_lat[1] = ITER_LAT;
    t_op[2] = OP_DIVU;  t_a[2] = 64'd100;  t_b[2] = 64'd0; t_exp[2] = 64'hFFFF_FFFF_FFFF_FFFF; t_lat[2] = FAST_LAT;
    t_op[3] = OP_REMU;  t_a[3] = 64'd100;  t_b[3] = 64'd0; t_exp[3] = 64'h64;                  t_lat[3] = FAST_LAT;
    t_op[4] = OP_DIVW;  t_a[4] = 64'hFFFF_FFFF_8000_0000; t_b[4] = '1; t_exp[4] = 64'hFFFF_FFFF_8000_0000; t_lat[4] = FAST_LAT;
    t_op[5] = OP_REMW;  t_a[5] = 64'hFFFF_FFFF_8000_0000; t_b[5] = '1; t_exp[5] = 64'd0;                  t_lat[5] = FAST_LAT;
    t_op[6] = OP_REMUW; t_a[6] = 64'h0000_0000_FFFF_FFFF; t_b[6] = 64'h10; t_exp[6] = 64'hF;               t_lat[6] = ITER_LAT;
    t_op[7] = OP_DIVUW; t_a[7] = 64'h0000_0000_FFFF_FFFF; t_b[7] = 64'h10; t_exp[7] = 64'h0000_0000_0FFF_FFFF; t_lat[7] = ITER_LAT;
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i], lat, got);
      checks++;
      if (lat !== t_lat[i]) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, t_lat[i]);
      end
      checks++;
      if (got !== t_exp[i]) begin
        errors++; $display("FAIL directed_data[%0d]: got %h expected %h", i, got, t_exp[i]);
      end
      @(negedge clk);
      checks++;
      if (div_finish !== 1'b0 || div_rem_data !== t_exp[i]) begin
        errors++; $display("FAIL directed_pulse[%0d]: finish %b data %h expected 0 and %h",
                           i, div_finish, div_rem_data, t_exp[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [63:0] prev;
    int          pulses;
    int          lat;
    logic [63:0] got;
    prev = div_rem_data;
    pulses = 0;
    @(negedge clk);
    div_ready = 1'b1; inst_opcode = 8'h00; dividend = 64'd9; diviser = 64'd3;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (div_finish) pulses++;
    end
    div_ready = 1'b0;
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL invalid_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (div_rem_data !== prev) begin
      errors++; $display("FAIL invalid_data_hold: got %h expected %h", div_rem_data, prev);
    end
    issue(OP_DIVU, 64'd9, 64'd3, lat, got);
    checks++;
    if (lat !== ITER_LAT || got !== 64'd3) begin
      errors++; $display("FAIL invalid_then_valid: lat %0d data %h expected %0d and %h",
                         lat, got, ITER_LAT, 64'd3);
    end
  endtask

  task automatic test_abort();
    logic [63:0] prev, a;
    int          pulses;
    int          lat;
    logic [63:0] got;
    prev = div_rem_data;
    pulses = 0;
    a = rnd64();
    @(negedge clk);
    div_ready = 1'b1; inst_opcode = OP_DIV; dividend = a; diviser = 64'd13;
    repeat (20) @(negedge clk);
    div_ready = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (div_finish) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL abort_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (div_rem_data !== prev) begin
      errors++; $display("FAIL abort_data_hold: got %h expected %h", div_rem_data, prev);
    end
    issue(OP_REM, a, 64'd13, lat, got);
    checks++;
    if (lat !== ITER_LAT || got !== model(OP_REM, a, 64'd13)) begin
      errors++; $display("FAIL abort_then_new: lat %0d data %h expected %0d and %h",
                         lat, got, ITER_LAT, model(OP_REM, a, 64'd13));
    end
  endtask

  task automatic test_operand_change();
    int lat;
    lat = -1;
    @(negedge clk);
    div_ready = 1'b1; inst_opcode = OP_DIVU; dividend = 64'd1000; diviser = 64'd7;
    repeat (10) @(negedge clk);
    inst_opcode = OP_REM; dividend = -64'sd5; diviser = 64'd3;
    for (int n = 11; n <= BUDGET; n++) begin
      @(negedge clk);
      if (div_finish) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== ITER_LAT || div_rem_data !== 64'd142) begin
      errors++; $display("FAIL operand_change: lat %0d data %h expected %0d and %h",
                         lat, div_rem_data, ITER_LAT, 64'd142);
    end
    div_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int          lat;
    logic [63:0] got;
    issue(OP_DIVU, 64'd100, 64'd0, lat, got);
    checks++;
    if (got !== '1) begin
      errors++; $display("FAIL prereset_data: got %h expected %h", got, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    @(negedge clk);
    div_ready = 1'b1; inst_opcode = OP_DIVU; dividend = 64'd12345; diviser = 64'd17;
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (div_rem_data !== 64'd0 || div_finish !== 1'b0) begin
      errors++; $display("FAIL async_reset_immediate: data %h finish %b expected 0 and 0",
                         div_rem_data, div_finish);
    end
    div_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (div_rem_data !== 64'd0 || div_finish !== 1'b0) begin
      errors++; $display("FAIL async_reset_held: data %h finish %b expected 0 and 0",
                         div_rem_data, div_finish);
    end
    rst = 1'b1;
    issue(OP_DIVU, 64'd12345, 64'd17, lat, got);
    checks++;
    if (lat !== ITER_LAT || got !== 64'd726) begin
      errors++; $display("FAIL after_reset_op: lat %0d data %h expected %0d and %h",
                         lat, got, ITER_LAT, 64'd726);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    @(negedge clk);
    div_ready = 1'b1; inst_opcode = OP_DIVU; dividend = 64'd50; diviser = 64'd5;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (div_finish) begin
        t1 = n;
        break;
      end
    end
    checks++;
    if (t1 !== ITER_LAT || div_rem_data !== 64'd10) begin
      errors++; $display("FAIL b2b_first: lat %0d data %h expected %0d and %h",
                         t1, div_rem_data, ITER_LAT, 64'd10);
    end
    inst_opcode = OP_REMU; dividend = 64'd50; diviser = 64'd7;
    @(negedge clk);
    checks++;
    if (div_finish !== 1'b0) begin
      errors++; $display("FAIL b2b_pulse_width: got %b expected 0", div_finish);
    end
    for (int n = 2; n <= BUDGET; n++) begin
      @(negedge clk);
      if (div_finish) begin
        t2 = t1 + n;
        break;
      end
    end
    checks++;
    if (t2 - t1 !== 66) begin
      errors++; $display("FAIL b2b_gap: got %0d expected 66", t2 - t1);
    end
    checks++;
    if (div_rem_data !== 64'd1) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", div_rem_data, 64'd1);
    end
    div_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [63:0] a, b, exp_data;
    bit          is_w, is_sgn, fast;
    int          kind, exp_lat, lat;
    logic [63:0] got;
    for (int i = 0; i < 24; i++) begin
      op = OP_DIV + 8'($urandom_range(0, 7));
      is_w   = op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
      is_sgn = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
      kind = $urandom_range(0, 5);
      a = rnd64(); b = rnd64();
      case (kind)
        0: b = 64'd0;
        1: begin
          b = 64'($urandom_range(1, 300));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        2: begin
          a = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
          b = '1;
        end
        3: b = '1;
        4: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      if (is_w && is_sgn) begin
        a = {{32{a[31]}}, a[31:0]};
        b = {{32{b[31]}}, b[31:0]};
      end else if (is_w) begin
        a = {32'd0, a[31:0]};
        b = {32'd0, b[31:0]};
      end
      fast = (b == 64'd0) ||
             (is_sgn && b == '1 &&
              a == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      exp_lat  = fast ? FAST_LAT : ITER_LAT;
      exp_data = model(op, a, b);
      issue(op, a, b, lat, got);
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL random_latency[%0d] op %h: got %0d expected %0d", i, op, lat, exp_lat);
      end
      checks++;
      if (got !== exp_data) begin
        errors++; $display("FAIL random_data[%0d] op %h a %h b %h: got %h expected %h",
                           i, op, a, b, got, exp_data);
      end
    end
  endtask

  initial begin
    rst = 1'b0; div_ready = 1'b0; inst_opcode = 8'h00; dividend = '0; diviser = '0;
    test_reset();
    test_directed();
    test_invalid();
    test_abort();
    test_operand_change();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
